// File: rtl/venus_pkg.sv
// Shared definitions for the venus pipeline: instruction field positions,
// opcode-class codes, the decoded bundle layout and the bubble constant.
package venus_pkg;

  // Instruction field bit positions
  localparam int unsigned OPC_MSB  = 31;
  localparam int unsigned OPC_LSB  = 25;
  localparam int unsigned RD_MSB   = 24;
  localparam int unsigned RD_LSB   = 21;
  localparam int unsigned RS_MSB   = 20;
  localparam int unsigned RS_LSB   = 17;
  localparam int unsigned IMMF_BIT = 16;
  localparam int unsigned IMM_MSB  = 15;
  localparam int unsigned IMM_LSB  = 0;

  // Opcode classes, taken from opcode[6:4]; 3'b111 also decodes as nop
  localparam logic [2:0] CLS_INTE  = 3'b000;
  localparam logic [2:0] CLS_LOGIC = 3'b001;
  localparam logic [2:0] CLS_SHIFT = 3'b010;
  localparam logic [2:0] CLS_LD    = 3'b011;
  localparam logic [2:0] CLS_ST    = 3'b100;
  localparam logic [2:0] CLS_BR    = 3'b101;
  localparam logic [2:0] NOP       = 3'b110;

  typedef struct packed {
    logic inte;
    logic lgc;
    logic shift;
    logic ld;
    logic st;
    logic br;
  } ctrl_t;

  typedef struct packed {
    ctrl_t       ctrl;
    logic        immf;
    logic [6:0]  opcode;
    logic [3:0]  rd_addr;
    logic [31:0] rd_value;
    logic [31:0] rs_value;
    logic [31:0] imm_value;
    logic [15:0] pc_value;
  } bundle_t;

  // All-zero bundle; the stage substitutes its RESET_PC into pc_value.
  // Execute sees it as a write to r0, which is harmless.
  localparam bundle_t BUBBLE = '0;

  // Map an opcode class onto the one-hot control bits
  function automatic ctrl_t decode_class(input logic [2:0] cls);
    ctrl_t c;
    c = '0;
    case (cls)
      CLS_INTE:  c.inte  = 1'b1;
      CLS_LOGIC: c.lgc   = 1'b1;
      CLS_SHIFT: c.shift = 1'b1;
      CLS_LD:    c.ld    = 1'b1;
      CLS_ST:    c.st    = 1'b1;
      CLS_BR:    c.br    = 1'b1;
      default:   c       = '0;
    endcase
    return c;
  endfunction

  // Sign-extend the 16-bit immediate field
  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/id_stage_regfile.sv
// 16x32 general register file: r0 hardwired to zero, two combinational
// read ports, one write port, write-through bypass on reads.
module regfile
  import venus_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  ra_addr,
  input  logic [3:0]  rb_addr,
  output logic [31:0] ra_data,
  output logic [31:0] rb_data,
  input  logic        we,
  input  logic [3:0]  waddr,
  input  logic [31:0] wdata
);

  logic [31:0] mem_r [16];

  // Register storage: cleared on reset, writes to r0 dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        mem_r[i] <= 32'h0000_0000;
      end
    end else if (we && (waddr != 4'd0)) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Read port A with write-through bypass
  always_comb begin
    ra_data = 32'h0000_0000;
    if (ra_addr == 4'd0) begin
      ra_data = 32'h0000_0000;
    end else if (we && (waddr == ra_addr)) begin
      ra_data = wdata;
    end else begin
      ra_data = mem_r[ra_addr];
    end
  end

  // Read port B with write-through bypass
  always_comb begin
    rb_data = 32'h0000_0000;
    if (rb_addr == 4'd0) begin
      rb_data = 32'h0000_0000;
    end else if (we && (waddr == rb_addr)) begin
      rb_data = wdata;
    end else begin
      rb_data = mem_r[rb_addr];
    end
  end

endmodule

// File: rtl/id_stage.sv
// Decode / register-read stage: decodes one instruction per cycle, reads
// operands, registers the bundle for execute, and handles RAW bubbles,
// execute back-pressure and branch flushes.
module id_stage
  import venus_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        v_i,
  input  logic [31:0] inst_i,
  input  logic [15:0] pc_i,
  output logic        stall_o,
  input  logic        ex_stall_i,
  input  logic        branch_en_i,
  input  logic        wb_en_i,
  input  logic [3:0]  wb_addr_i,
  input  logic [31:0] wb_data_i,
  output logic [31:0] rd_value_o,
  output logic [31:0] rs_value_o,
  output logic [31:0] imm_value_o,
  output logic [3:0]  rd_addr_o,
  output logic [15:0] pc_value_o,
  output logic [6:0]  opcode_o,
  output logic        ctrl_inte_o,
  output logic        ctrl_logic_o,
  output logic        ctrl_shift_o,
  output logic        ctrl_ld_o,
  output logic        ctrl_st_o,
  output logic        ctrl_br_o,
  output logic        immf_o
);

  logic [3:0]  dec_rd_s;
  logic [3:0]  dec_rs_s;
  logic        dec_immf_s;
  logic [31:0] rd_data_s;
  logic [31:0] rs_data_s;
  bundle_t     bubble_s;
  bundle_t     dec_s;
  bundle_t     next_s;
  bundle_t     out_r;
  logic        producer_s;
  logic        hazard_s;

  assign dec_rd_s   = inst_i[RD_MSB:RD_LSB];
  assign dec_rs_s   = inst_i[RS_MSB:RS_LSB];
  assign dec_immf_s = inst_i[IMMF_BIT];

  regfile u_regfile (
    .clk     (clk),
    .rst     (rst),
    .ra_addr (dec_rd_s),
    .rb_addr (dec_rs_s),
    .ra_data (rd_data_s),
    .rb_data (rs_data_s),
    .we      (wb_en_i),
    .waddr   (wb_addr_i),
    .wdata   (wb_data_i)
  );

  // Bubble bundle carrying this stage's reset PC
  always_comb begin
    bubble_s          = BUBBLE;
    bubble_s.pc_value = RESET_PC;
  end

  // Decode the fetched instruction into an execute bundle
  always_comb begin
    dec_s           = BUBBLE;
    dec_s.opcode    = inst_i[OPC_MSB:OPC_LSB];
    dec_s.ctrl      = decode_class(inst_i[OPC_MSB:OPC_MSB-2]);
    dec_s.immf      = dec_immf_s;
    dec_s.rd_addr   = dec_rd_s;
    dec_s.rd_value  = rd_data_s;
    dec_s.rs_value  = rs_data_s;
    dec_s.imm_value = sext16(inst_i[IMM_MSB:IMM_LSB]);
    dec_s.pc_value  = pc_i;
  end

  // RAW hazard against the register-writing instruction now in execute
  always_comb begin
    producer_s = !out_r.ctrl.st && !out_r.ctrl.br && (out_r.rd_addr != 4'd0);
    hazard_s   = 1'b0;
    if (v_i && producer_s) begin
      if (dec_rd_s == out_r.rd_addr) begin
        hazard_s = 1'b1;
      end else if (!dec_immf_s && (dec_rs_s == out_r.rd_addr)) begin
        hazard_s = 1'b1;
      end else begin
        hazard_s = 1'b0;
      end
    end else begin
      hazard_s = 1'b0;
    end
  end

  // Fetch hold request; a flush always lets fetch move to the target
  always_comb begin
    stall_o = 1'b0;
    if (rst) begin
      stall_o = 1'b0;
    end else if (branch_en_i) begin
      stall_o = 1'b0;
    end else if (ex_stall_i) begin
      stall_o = 1'b1;
    end else if (hazard_s) begin
      stall_o = 1'b1;
    end else begin
      stall_o = 1'b0;
    end
  end

  // Next output bundle: flush > execute hold > hazard bubble > load
  always_comb begin
    next_s = bubble_s;
    if (branch_en_i) begin
      next_s = bubble_s;
    end else if (ex_stall_i) begin
      next_s = out_r;
    end else if (hazard_s) begin
      next_s = bubble_s;
    end else if (!v_i) begin
      next_s = bubble_s;
    end else begin
      next_s = dec_s;
    end
  end

  // Output bundle register
  always_ff @(posedge clk) begin
    if (rst) begin
      out_r <= bubble_s;
    end else begin
      out_r <= next_s;
    end
  end

  // Bundle outputs; a taken branch kills the instruction in execute at once
  always_comb begin
    rd_value_o  = out_r.rd_value;
    rs_value_o  = out_r.rs_value;
    imm_value_o = out_r.imm_value;
    pc_value_o  = out_r.pc_value;
    opcode_o    = out_r.opcode;
    immf_o      = out_r.immf;
    if (branch_en_i) begin
      ctrl_inte_o  = 1'b0;
      ctrl_logic_o = 1'b0;
      ctrl_shift_o = 1'b0;
      ctrl_ld_o    = 1'b0;
      ctrl_st_o    = 1'b0;
      ctrl_br_o    = 1'b0;
      rd_addr_o    = 4'd0;
    end else begin
      ctrl_inte_o  = out_r.ctrl.inte;
      ctrl_logic_o = out_r.ctrl.lgc;
      ctrl_shift_o = out_r.ctrl.shift;
      ctrl_ld_o    = out_r.ctrl.ld;
      ctrl_st_o    = out_r.ctrl.st;
      ctrl_br_o    = out_r.ctrl.br;
      rd_addr_o    = out_r.rd_addr;
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Directed self-checking bench for id_stage.
module tb_id_stage;

  localparam logic [15:0] TB_RESET_PC = 16'h00F0;

  logic        clk = 1'b0;
  logic        rst, v_i, ex_stall_i, branch_en_i, wb_en_i, stall_o;
  logic [31:0] inst_i, wb_data_i;
  logic [15:0] pc_i, pc_value_o;
  logic [3:0]  wb_addr_i, rd_addr_o;
  logic [31:0] rd_value_o, rs_value_o, imm_value_o;
  logic [6:0]  opcode_o;
  logic        ctrl_inte_o, ctrl_logic_o, ctrl_shift_o, ctrl_ld_o, ctrl_st_o, ctrl_br_o, immf_o;
  logic [6:0]  ctrl_bits;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign ctrl_bits = {ctrl_inte_o, ctrl_logic_o, ctrl_shift_o, ctrl_ld_o, ctrl_st_o, ctrl_br_o, immf_o};

  id_stage #(.RESET_PC(TB_RESET_PC)) dut (
    .clk(clk), .rst(rst), .v_i(v_i), .inst_i(inst_i), .pc_i(pc_i), .stall_o(stall_o),
    .ex_stall_i(ex_stall_i), .branch_en_i(branch_en_i), .wb_en_i(wb_en_i),
    .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i), .rd_value_o(rd_value_o),
    .rs_value_o(rs_value_o), .imm_value_o(imm_value_o), .rd_addr_o(rd_addr_o),
    .pc_value_o(pc_value_o), .opcode_o(opcode_o), .ctrl_inte_o(ctrl_inte_o),
    .ctrl_logic_o(ctrl_logic_o), .ctrl_shift_o(ctrl_shift_o), .ctrl_ld_o(ctrl_ld_o),
    .ctrl_st_o(ctrl_st_o), .ctrl_br_o(ctrl_br_o), .immf_o(immf_o)
  );

  function automatic logic [31:0] mk_inst(input logic [6:0] op, input logic [3:0] rd,
                                          input logic [3:0] rs, input logic immf,
                                          input logic [15:0] imm);
    return {op, rd, rs, immf, imm};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    v_i = 1'b0; wb_en_i = 1'b0; ex_stall_i = 1'b0; branch_en_i = 1'b0;
    tick();
  endtask

  task automatic test_reset;
    rst = 1'b1; v_i = 1'b0; ex_stall_i = 1'b0; branch_en_i = 1'b0; wb_en_i = 1'b0;
    wb_addr_i = 4'd0; wb_data_i = 32'h0; inst_i = 32'h0; pc_i = 16'h0;
    tick(); tick();
    rst = 1'b0; #1;
    n_checks++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL rst_stall: got %b exp 0", stall_o); end
    n_checks++; if (ctrl_bits !== 7'h00) begin n_fail++; $display("FAIL rst_ctrl: got %h exp 00", ctrl_bits); end
    n_checks++; if (rd_addr_o !== 4'd0) begin n_fail++; $display("FAIL rst_rd_addr: got %h exp 0", rd_addr_o); end
    n_checks++; if ({rd_value_o, rs_value_o, imm_value_o} !== 96'h0) begin n_fail++; $display("FAIL rst_values: got %h %h %h exp 0", rd_value_o, rs_value_o, imm_value_o); end
    n_checks++; if (opcode_o !== 7'h00) begin n_fail++; $display("FAIL rst_opcode: got %h exp 00", opcode_o); end
    n_checks++; if (pc_value_o !== TB_RESET_PC) begin n_fail++; $display("FAIL rst_pc: got %h exp %h", pc_value_o, TB_RESET_PC); end
  endtask

  task automatic test_imm_decode;
    idle();
    v_i = 1'b1; inst_i = mk_inst(7'h00, 4'd3, 4'd0, 1'b1, 16'hFFFE); pc_i = 16'h0010;
    tick();
    v_i = 1'b0; #1;
    n_checks++; if (ctrl_bits !== 7'b1000001) begin n_fail++; $display("FAIL imm_ctrl: got %b exp 1000001", ctrl_bits); end
    n_checks++; if (imm_value_o !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL imm_value: got %h exp FFFFFFFE", imm_value_o); end
    n_checks++; if (rd_addr_o !== 4'd3) begin n_fail++; $display("FAIL imm_rd_addr: got %h exp 3", rd_addr_o); end
    n_checks++; if (pc_value_o !== 16'h0010) begin n_fail++; $display("FAIL imm_pc: got %h exp 0010", pc_value_o); end
  endtask

  task automatic test_write_through;
    idle();
    wb_en_i = 1'b1; wb_addr_i = 4'd5; wb_data_i = 32'h12345678;
    v_i = 1'b1; inst_i = mk_inst(7'h10, 4'd6, 4'd5, 1'b0, 16'h0000); pc_i = 16'h0020;
    tick();
    wb_en_i = 1'b0; #1;
    n_checks++; if (rs_value_o !== 32'h12345678) begin n_fail++; $display("FAIL wt_rs: got %h exp 12345678", rs_value_o); end
    n_checks++; if (ctrl_logic_o !== 1'b1) begin n_fail++; $display("FAIL wt_logic: got %b exp 1", ctrl_logic_o); end
    wb_en_i = 1'b1; wb_addr_i = 4'd0; wb_data_i = 32'hDEADBEEF;
    inst_i = mk_inst(7'h10, 4'd7, 4'd0, 1'b0, 16'h0000); pc_i = 16'h0024;
    tick();
    wb_en_i = 1'b0; #1;
    n_checks++; if (rs_value_o !== 32'h0) begin n_fail++; $display("FAIL wt_r0: got %h exp 0", rs_value_o); end
    inst_i = mk_inst(7'h11, 4'd5, 4'd5, 1'b0, 16'h0000); pc_i = 16'h0028;
    tick();
    v_i = 1'b0; #1;
    n_checks++; if ({rd_value_o, rs_value_o} !== {32'h12345678, 32'h12345678}) begin n_fail++; $display("FAIL wt_stored: got %h %h exp 12345678 12345678", rd_value_o, rs_value_o); end
  endtask

  task automatic test_raw_stall;
    idle();
    v_i = 1'b1; inst_i = mk_inst(7'h00, 4'd2, 4'd1, 1'b0, 16'h0000); pc_i = 16'h0030; #1;
    n_checks++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL raw_nostall_first: got %b exp 0", stall_o); end
    tick();
    inst_i = mk_inst(7'h20, 4'd9, 4'd2, 1'b0, 16'h0000); pc_i = 16'h0034; #1;
    n_checks++; if (stall_o !== 1'b1) begin n_fail++; $display("FAIL raw_stall: got %b exp 1", stall_o); end
    tick();
    n_checks++; if ({ctrl_bits, rd_addr_o, pc_value_o} !== {7'h00, 4'd0, TB_RESET_PC}) begin n_fail++; $display("FAIL raw_bubble: got %h %h %h exp 00 0 %h", ctrl_bits, rd_addr_o, pc_value_o, TB_RESET_PC); end
    wb_en_i = 1'b1; wb_addr_i = 4'd2; wb_data_i = 32'hCAFEF00D; #1;
    n_checks++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL raw_one_cycle: got %b exp 0", stall_o); end
    tick();
    wb_en_i = 1'b0; #1;
    n_checks++; if ({ctrl_shift_o, rd_addr_o, pc_value_o} !== {1'b1, 4'd9, 16'h0034}) begin n_fail++; $display("FAIL raw_issue: got %b %h %h exp 1 9 0034", ctrl_shift_o, rd_addr_o, pc_value_o); end
    n_checks++; if (rs_value_o !== 32'hCAFEF00D) begin n_fail++; $display("FAIL raw_rs: got %h exp CAFEF00D", rs_value_o); end
  endtask

  task automatic test_back_to_back;
    // Output holds shift to r9; next reads r9
    inst_i = mk_inst(7'h02, 4'd10, 4'd9, 1'b0, 16'h0000); pc_i = 16'h0038; #1;
    n_checks++; if (stall_o !== 1'b1) begin n_fail++; $display("FAIL b2b_stall1: got %b exp 1", stall_o); end
    tick();
    wb_en_i = 1'b1; wb_addr_i = 4'd9; wb_data_i = 32'h0BADC0DE; #1;
    n_checks++; if ({stall_o, rd_addr_o} !== {1'b0, 4'd0}) begin n_fail++; $display("FAIL b2b_release1: got %b %h exp 0 0", stall_o, rd_addr_o); end
    tick();
    wb_en_i = 1'b0;
    // rd-only dependence: immf set, rs field ignored
    inst_i = mk_inst(7'h03, 4'd10, 4'd4, 1'b1, 16'h8000); pc_i = 16'h003C; #1;
    n_checks++; if ({rd_addr_o, rs_value_o, stall_o} !== {4'd10, 32'h0BADC0DE, 1'b1}) begin n_fail++; $display("FAIL b2b_stall2: got %h %h %b exp a 0BADC0DE 1", rd_addr_o, rs_value_o, stall_o); end
    tick();
    wb_en_i = 1'b1; wb_addr_i = 4'd10; wb_data_i = 32'h00000005; #1;
    n_checks++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL b2b_release2: got %b exp 0", stall_o); end
    tick();
    wb_en_i = 1'b0; #1;
    n_checks++; if ({ctrl_inte_o, imm_value_o, rd_value_o} !== {1'b1, 32'hFFFF8000, 32'h5}) begin n_fail++; $display("FAIL b2b_issue2: got %b %h %h exp 1 FFFF8000 5", ctrl_inte_o, imm_value_o, rd_value_o); end
    inst_i = mk_inst(7'h00, 4'd11, 4'd10, 1'b1, 16'h0000); #1;
    n_checks++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL b2b_immf_rs: got %b exp 0", stall_o); end
    v_i = 1'b0;
  endtask

  task automatic test_flush;
    idle();
    v_i = 1'b1; inst_i = mk_inst(7'h00, 4'd4, 4'd0, 1'b1, 16'h0005); pc_i = 16'h0040;
    tick();
    n_checks++; if ({ctrl_inte_o, rd_addr_o} !== {1'b1, 4'd4}) begin n_fail++; $display("FAIL flush_pre: got %b %h exp 1 4", ctrl_inte_o, rd_addr_o); end
    inst_i = mk_inst(7'h00, 4'd6, 4'd4, 1'b0, 16'h0000); pc_i = 16'h0044; branch_en_i = 1'b1; #1;
    n_checks++; if ({ctrl_inte_o, rd_addr_o, stall_o} !== {1'b0, 4'd0, 1'b0}) begin n_fail++; $display("FAIL flush_kill: got %b %h %b exp 0 0 0", ctrl_inte_o, rd_addr_o, stall_o); end
    tick();
    branch_en_i = 1'b0; v_i = 1'b0; #1;
    n_checks++; if ({ctrl_bits, rd_addr_o, pc_value_o, stall_o} !== {7'h00, 4'd0, TB_RESET_PC, 1'b0}) begin n_fail++; $display("FAIL flush_bubble: got %h %h %h %b exp 00 0 %h 0", ctrl_bits, rd_addr_o, pc_value_o, stall_o, TB_RESET_PC); end
  endtask

  task automatic test_ex_stall;
    idle();
    v_i = 1'b1; inst_i = mk_inst(7'h10, 4'd11, 4'd0, 1'b1, 16'h0000); pc_i = 16'h0050;
    tick();
    inst_i = mk_inst(7'h10, 4'd13, 4'd12, 1'b0, 16'h0000); pc_i = 16'h0054;
    ex_stall_i = 1'b1; wb_en_i = 1'b1; wb_addr_i = 4'd12; wb_data_i = 32'h00C0FFEE; #1;
    n_checks++; if (stall_o !== 1'b1) begin n_fail++; $display("FAIL exs_stall: got %b exp 1", stall_o); end
    tick();
    wb_en_i = 1'b0; #1;
    n_checks++; if ({pc_value_o, rd_addr_o} !== {16'h0050, 4'd11}) begin n_fail++; $display("FAIL exs_hold: got %h %h exp 0050 b", pc_value_o, rd_addr_o); end
    ex_stall_i = 1'b0; #1;
    n_checks++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL exs_release: got %b exp 0", stall_o); end
    tick();
    v_i = 1'b0; #1;
    n_checks++; if ({pc_value_o, rd_addr_o, rs_value_o} !== {16'h0054, 4'd13, 32'h00C0FFEE}) begin n_fail++; $display("FAIL exs_issue: got %h %h %h exp 0054 d 00C0FFEE", pc_value_o, rd_addr_o, rs_value_o); end
  endtask

  task automatic test_st_br_producer;
    idle();
    v_i = 1'b1; inst_i = mk_inst(7'h40, 4'd6, 4'd1, 1'b0, 16'h0000); pc_i = 16'h0060;
    tick();
    n_checks++; if (ctrl_st_o !== 1'b1) begin n_fail++; $display("FAIL st_ctrl: got %b exp 1", ctrl_st_o); end
    inst_i = mk_inst(7'h00, 4'd6, 4'd6, 1'b0, 16'h0000); pc_i = 16'h0064; #1;
    n_checks++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL st_nostall: got %b exp 0", stall_o); end
    inst_i = mk_inst(7'h50, 4'd7, 4'd0, 1'b1, 16'h0010); pc_i = 16'h0068;
    tick();
    n_checks++; if ({ctrl_br_o, rd_addr_o} !== {1'b1, 4'd7}) begin n_fail++; $display("FAIL br_ctrl: got %b %h exp 1 7", ctrl_br_o, rd_addr_o); end
    inst_i = mk_inst(7'h00, 4'd7, 4'd7, 1'b0, 16'h0000); pc_i = 16'h006C; #1;
    n_checks++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL br_nostall: got %b exp 0", stall_o); end
    inst_i = mk_inst(7'h65, 4'd3, 4'd0, 1'b0, 16'h0000); pc_i = 16'h0070;
    tick();
    inst_i = mk_inst(7'h7F, 4'd8, 4'd0, 1'b0, 16'h0000); pc_i = 16'h0074; #1;
    n_checks++; if ({ctrl_bits, opcode_o, rd_addr_o} !== {7'h00, 7'h65, 4'd3}) begin n_fail++; $display("FAIL nop110: got %h %h %h exp 00 65 3", ctrl_bits, opcode_o, rd_addr_o); end
    tick();
    v_i = 1'b0; #1;
    n_checks++; if ({ctrl_bits, opcode_o} !== {7'h00, 7'h7F}) begin n_fail++; $display("FAIL nop111: got %h %h exp 00 7f", ctrl_bits, opcode_o); end
  endtask

  task automatic test_reset_mid_stall;
    idle();
    v_i = 1'b1; inst_i = mk_inst(7'h00, 4'd2, 4'd0, 1'b1, 16'h0000); pc_i = 16'h0080;
    tick();
    inst_i = mk_inst(7'h00, 4'd3, 4'd2, 1'b0, 16'h0000); pc_i = 16'h0084; #1;
    n_checks++; if (stall_o !== 1'b1) begin n_fail++; $display("FAIL rms_stall: got %b exp 1", stall_o); end
    rst = 1'b1; #1;
    n_checks++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL rms_rst_stall: got %b exp 0", stall_o); end
    tick();
    rst = 1'b0; v_i = 1'b0; #1;
    n_checks++; if ({ctrl_bits, rd_addr_o, pc_value_o} !== {7'h00, 4'd0, TB_RESET_PC}) begin n_fail++; $display("FAIL rms_bubble: got %h %h %h exp 00 0 %h", ctrl_bits, rd_addr_o, pc_value_o, TB_RESET_PC); end
    // Register file must be cleared by reset (r5 held 12345678)
    v_i = 1'b1; inst_i = mk_inst(7'h10, 4'd1, 4'd5, 1'b0, 16'h0000); pc_i = 16'h0000;
    tick();
    v_i = 1'b0; #1;
    n_checks++; if (rs_value_o !== 32'h0) begin n_fail++; $display("FAIL rms_rf_clear: got %h exp 0", rs_value_o); end
  endtask

  initial begin
    test_reset();
    test_imm_decode();
    test_write_through();
    test_raw_stall();
    test_back_to_back();
    test_flush();
    test_ex_stall();
    test_st_br_producer();
    test_reset_mid_stall();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
